// File: rtl/lbist_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lbist_seq_ctrl_pkg
// Shared definitions for the LBIST sequencer:
//   - lbistState_t : FSM state codes (IDLE, CLEAR, APPLY, COMPARE, DONE)
//   - MODE_*       : pattern-source mode encodings (2'b11 behaves as 2'b00)
//   - lfsrTapMask  : primitive-polynomial tap mask for LFSR widths 4..16
//   - modeHasDtp / modeHasRtp : which pattern phases a mode contains
// -----------------------------------------------------------------------------
package lbist_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_APPLY   = 3'd2,
      ST_COMPARE = 3'd3,
      ST_DONE    = 3'd4
   } lbistState_t;

   localparam logic [1:0] MODE_DTP_RTP  = 2'b00;
   localparam logic [1:0] MODE_DTP_ONLY = 2'b01;
   localparam logic [1:0] MODE_RTP_ONLY = 2'b10;

   // Tap bit positions (0-based) of a maximal-length Fibonacci LFSR for each
   // supported width; the feedback bit is the XOR of the masked state bits.
   function automatic logic [15:0] lfsrTapMask(input int width);
      case (width)
         4:       return 16'h000C;
         5:       return 16'h0014;
         6:       return 16'h0030;
         7:       return 16'h0060;
         8:       return 16'h00B8;
         9:       return 16'h0110;
         10:      return 16'h0240;
         11:      return 16'h0500;
         12:      return 16'h0829;
         13:      return 16'h100D;
         14:      return 16'h2015;
         15:      return 16'h6000;
         16:      return 16'hD008;
         default: return 16'h000C;
      endcase
   endfunction

   function automatic logic modeHasDtp(input logic [1:0] mode);
      return (mode != MODE_RTP_ONLY);
   endfunction

   function automatic logic modeHasRtp(input logic [1:0] mode);
      return (mode != MODE_DTP_ONLY);
   endfunction

endpackage

// File: rtl/lbist_seq_ctrl_lfsr.sv
// -----------------------------------------------------------------------------
// lbist_seq_ctrl_lfsr
// Fibonacci LFSR producing the random test patterns. Shifts left, with the XOR
// of the tap bits fed into bit 0. A zero seed is replaced by 1 so the state can
// never lock up at 0.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset (state returns to the seed)
//   i_load  : reload the seed (wins over i_step)
//   i_step  : advance one state
//   o_state : current LFSR state
// -----------------------------------------------------------------------------
module lbist_seq_ctrl_lfsr
   import lbist_seq_ctrl_pkg::*;
#(
   parameter int                    INPUT_BITS = 4,
   parameter logic [INPUT_BITS-1:0] SEED       = INPUT_BITS'(1)
)(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_load,
   input  logic                  i_step,
   output logic [INPUT_BITS-1:0] o_state
);

   localparam logic [15:0]           TAP_ALL  = lfsrTapMask(INPUT_BITS);
   localparam logic [INPUT_BITS-1:0] TAPS     = TAP_ALL[INPUT_BITS-1:0];
   localparam logic [INPUT_BITS-1:0] SEED_EFF = (SEED == '0) ? INPUT_BITS'(1) : SEED;

   logic [INPUT_BITS-1:0] r_state;
   logic                  w_feedback;

   assign w_feedback = ^(r_state & TAPS);

   // State register: the seed is restored on reset and on every load so each
   // run replays exactly the same random sequence.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= SEED_EFF;
      end else if (i_load) begin
         r_state <= SEED_EFF;
      end else if (i_step) begin
         r_state <= {r_state[INPUT_BITS-2:0], w_feedback};
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/lbist_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lbist_seq_ctrl
// LBIST sequencer: one fault-free golden run followed by one run per injectable
// fault. Each run clears the ORA, applies deterministic (ROM) and/or LFSR
// patterns, then compares the ORA signature with the golden signature.
//   i_clk, i_rst_n     : clock / asynchronous active-low reset
//   i_start, i_abort   : start request (IDLE/DONE only), synchronous abort
//   i_mode             : 00/11 DTP then RTP, 01 DTP only, 10 RTP only
//   o_dtp_addr         : ROM address, i_dtp_data is the same-cycle ROM data
//   o_cut_in           : pattern applied to the CUT
//   o_fault_en/_id     : fault injection control
//   o_ora_clr/_en      : ORA control, i_ora_sig is the signature
//   o_res_vld/_fault_id/_detected : per-fault result strobe
//   o_det_count        : saturating count of detected faults
//   o_busy, o_done     : run status
// -----------------------------------------------------------------------------
module lbist_seq_ctrl
   import lbist_seq_ctrl_pkg::*;
#(
   parameter int                    INPUT_BITS = 4,
   parameter int                    RC_BITS    = 2,
   parameter int                    TOT_FAULTS = 100,
   parameter int                    NUM_DTP    = 100,
   parameter int                    NUM_RTP    = 100,
   parameter logic [INPUT_BITS-1:0] LFSR_SEED  = INPUT_BITS'(1),
   localparam int AW = (NUM_DTP > 1) ? $clog2(NUM_DTP) : 1,
   localparam int FW = (TOT_FAULTS > 1) ? $clog2(TOT_FAULTS) : 1,
   localparam int CW = $clog2(TOT_FAULTS + 1)
)(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic [1:0]            i_mode,
   output logic [AW-1:0]         o_dtp_addr,
   input  logic [INPUT_BITS-1:0] i_dtp_data,
   output logic [INPUT_BITS-1:0] o_cut_in,
   output logic                  o_fault_en,
   output logic [FW-1:0]         o_fault_id,
   output logic                  o_ora_clr,
   output logic                  o_ora_en,
   input  logic [RC_BITS-1:0]    i_ora_sig,
   output logic                  o_res_vld,
   output logic [FW-1:0]         o_res_fault_id,
   output logic                  o_res_detected,
   output logic [CW-1:0]         o_det_count,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int            IW         = $clog2(NUM_DTP + NUM_RTP + 1);
   localparam logic [IW-1:0] DTP_COUNT  = IW'(NUM_DTP);
   localparam logic [IW-1:0] LAST_BOTH  = IW'(NUM_DTP + NUM_RTP - 1);
   localparam logic [IW-1:0] LAST_DTP   = IW'(NUM_DTP - 1);
   localparam logic [IW-1:0] LAST_RTP   = IW'(NUM_RTP - 1);
   localparam logic [FW-1:0] LAST_FAULT = FW'(TOT_FAULTS - 1);
   localparam logic [CW-1:0] MAX_COUNT  = CW'(TOT_FAULTS);

   lbistState_t           r_state;
   lbistState_t           w_nextState;
   logic [IW-1:0]         r_index;
   logic [1:0]            r_mode;
   logic                  r_faultRun;
   logic [FW-1:0]         r_faultId;
   logic [RC_BITS-1:0]    r_golden;
   logic [CW-1:0]         r_detCount;

   logic                  w_busy;
   logic                  w_dtpPhase;
   logic                  w_rtpPhase;
   logic                  w_lastPattern;
   logic                  w_lastRun;
   logic                  w_resVld;
   logic                  w_detected;
   logic                  w_acceptStart;
   logic [IW-1:0]         w_lastIndex;
   logic [INPUT_BITS-1:0] w_lfsrState;

   // The run length depends on the mode latched at start; 2'b11 falls into
   // the default and behaves like DTP followed by RTP.
   always_comb begin
      w_lastIndex = LAST_BOTH;
      case (r_mode)
         MODE_DTP_ONLY: w_lastIndex = LAST_DTP;
         MODE_RTP_ONLY: w_lastIndex = LAST_RTP;
         default:       w_lastIndex = LAST_BOTH;
      endcase
   end

   assign w_busy        = (r_state == ST_CLEAR) || (r_state == ST_APPLY) || (r_state == ST_COMPARE);
   assign w_dtpPhase    = (r_state == ST_APPLY) && modeHasDtp(r_mode) && (r_index < DTP_COUNT);
   assign w_rtpPhase    = (r_state == ST_APPLY) && !w_dtpPhase;
   assign w_lastPattern = (r_index == w_lastIndex);
   assign w_lastRun     = r_faultRun && (r_faultId == LAST_FAULT);
   assign w_resVld      = (r_state == ST_COMPARE) && r_faultRun;
   assign w_detected    = w_resVld && (i_ora_sig != r_golden);
   assign w_acceptStart = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && i_start && !i_abort;

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Abort has priority everywhere, including over a start
   // arriving in the same IDLE/DONE cycle.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (i_abort) begin
               w_nextState = ST_IDLE;
            end else if (i_start) begin
               w_nextState = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            w_nextState = i_abort ? ST_IDLE : ST_APPLY;
         end
         ST_APPLY: begin
            if (i_abort) begin
               w_nextState = ST_IDLE;
            end else if (w_lastPattern) begin
               w_nextState = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            if (i_abort) begin
               w_nextState = ST_IDLE;
            end else if (w_lastRun) begin
               w_nextState = ST_DONE;
            end else begin
               w_nextState = ST_CLEAR;
            end
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   // Run bookkeeping: the run identity is updated on the way into CLEAR so
   // fault_en/fault_id are already correct during the CLEAR cycle. An abort
   // freezes the golden register and the detected count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_index    <= '0;
         r_mode     <= MODE_DTP_RTP;
         r_faultRun <= 1'b0;
         r_faultId  <= '0;
         r_golden   <= '0;
         r_detCount <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_acceptStart) begin
                  r_mode     <= i_mode;
                  r_faultRun <= 1'b0;
                  r_faultId  <= '0;
                  r_detCount <= '0;
               end
            end
            ST_CLEAR: begin
               r_index <= '0;
            end
            ST_APPLY: begin
               r_index <= r_index + IW'(1);
            end
            ST_COMPARE: begin
               if (!i_abort) begin
                  if (!r_faultRun) begin
                     r_golden   <= i_ora_sig;
                     r_faultRun <= 1'b1;
                     r_faultId  <= '0;
                  end else begin
                     if (w_detected && (r_detCount != MAX_COUNT)) begin
                        r_detCount <= r_detCount + CW'(1);
                     end
                     if (!w_lastRun) begin
                        r_faultId <= r_faultId + FW'(1);
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   lbist_seq_ctrl_lfsr #(
      .INPUT_BITS (INPUT_BITS),
      .SEED       (LFSR_SEED)
   ) u_lfsr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (r_state == ST_CLEAR),
      .i_step  (w_rtpPhase),
      .o_state (w_lfsrState)
   );

   assign o_dtp_addr     = w_dtpPhase ? r_index[AW-1:0] : '0;
   assign o_cut_in       = w_dtpPhase ? i_dtp_data : (w_rtpPhase ? w_lfsrState : '0);
   assign o_fault_en     = w_busy && r_faultRun;
   assign o_fault_id     = (w_busy && r_faultRun) ? r_faultId : '0;
   assign o_ora_clr      = (r_state == ST_CLEAR);
   assign o_ora_en       = (r_state == ST_APPLY);
   assign o_res_vld      = w_resVld;
   assign o_res_fault_id = w_resVld ? r_faultId : '0;
   assign o_res_detected = w_detected;
   assign o_det_count    = r_detCount;
   assign o_busy         = w_busy;
   assign o_done         = (r_state == ST_DONE);

endmodule

// File: tb/tb_lbist_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lbist_seq_ctrl
// Bench for lbist_seq_ctrl with INPUT_BITS=4, NUM_DTP=4, NUM_RTP=8,
// TOT_FAULTS=3, seed 1, RC_BITS=8. Models the pattern ROM and a rotate-XOR
// ORA whose response is flipped while a fault from detMask is injected.
// Every cycle of a sequence is predicted from its position in the schedule.
// -----------------------------------------------------------------------------
module tb_lbist_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [1:0] mode;
   logic [1:0] dtpAddr;
   logic [3:0] dtpData;
   logic [3:0] cutIn;
   logic       faultEn;
   logic [1:0] faultId;
   logic       oraClr;
   logic       oraEn;
   logic [7:0] oraSig;
   logic       resVld;
   logic [1:0] resFaultId;
   logic       resDetected;
   logic [1:0] detCount;
   logic       busy;
   logic       done;

   logic [3:0] rom [4];
   logic [2:0] detMask;
   int         checks = 0;
   int         errors = 0;
   int         rtpSeq [8] = '{1, 2, 4, 9, 3, 6, 13, 10};

   lbist_seq_ctrl #(
      .INPUT_BITS (4),
      .RC_BITS    (8),
      .TOT_FAULTS (3),
      .NUM_DTP    (4),
      .NUM_RTP    (8),
      .LFSR_SEED  (4'd1)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start        (start),
      .i_abort        (abort),
      .i_mode         (mode),
      .o_dtp_addr     (dtpAddr),
      .i_dtp_data     (dtpData),
      .o_cut_in       (cutIn),
      .o_fault_en     (faultEn),
      .o_fault_id     (faultId),
      .o_ora_clr      (oraClr),
      .o_ora_en       (oraEn),
      .i_ora_sig      (oraSig),
      .o_res_vld      (resVld),
      .o_res_fault_id (resFaultId),
      .o_res_detected (resDetected),
      .o_det_count    (detCount),
      .o_busy         (busy),
      .o_done         (done)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational pattern ROM.
   assign dtpData = rom[dtpAddr];

   // ORA model: rotate-XOR compactor over the CUT response; a fault listed in
   // detMask flips response bit 0 on every captured cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oraSig <= 8'h00;
      end else if (oraClr) begin
         oraSig <= 8'h00;
      end else if (oraEn) begin
         oraSig <= {oraSig[6:0], oraSig[7]} ^ {4'h0, cutIn}
                   ^ ((faultEn && detMask[faultId]) ? 8'h01 : 8'h00);
      end
   end

   // Safety net so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int runLength(input logic [1:0] m);
      case (m)
         2'b01:   return 4;
         2'b10:   return 8;
         default: return 12;
      endcase
   endfunction

   // Faults counted as detected by cycle c: their compare cycle lies before c.
   function automatic int expectedCount(input int c, input int n, input logic [2:0] msk);
      int cnt = 0;
      for (int f = 0; f < 3; f++) begin
         if (msk[f] && ((f + 2) * (n + 2) < c)) cnt++;
      end
      return cnt;
   endfunction

   // One comparison point.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // All outputs quiet except det_count.
   task automatic checkQuiet(input string phase, input int expCount);
      checkOutput({phase, ".busy"},         32'(busy),        0);
      checkOutput({phase, ".done"},         32'(done),        0);
      checkOutput({phase, ".ora_clr"},      32'(oraClr),      0);
      checkOutput({phase, ".ora_en"},       32'(oraEn),       0);
      checkOutput({phase, ".cut_in"},       32'(cutIn),       0);
      checkOutput({phase, ".dtp_addr"},     32'(dtpAddr),     0);
      checkOutput({phase, ".fault_en"},     32'(faultEn),     0);
      checkOutput({phase, ".fault_id"},     32'(faultId),     0);
      checkOutput({phase, ".res_vld"},      32'(resVld),      0);
      checkOutput({phase, ".res_fault_id"}, 32'(resFaultId),  0);
      checkOutput({phase, ".res_detected"}, 32'(resDetected), 0);
      checkOutput({phase, ".det_count"},    32'(detCount),    32'(expCount));
   endtask

   // Predict every output for cycle c after start from the run schedule:
   // runs of n+2 cycles (clear, n patterns, compare), golden run first.
   task automatic checkCycle(input int c, input int n, input logic [1:0] m, input logic [2:0] msk);
      int    runLen = n + 2;
      int    total  = 1 + 4 * runLen;
      int    r, p, idx, dtpLen;
      int    eBusy = 0, eDone = 0, eClr = 0, eEn = 0, eCut = 0, eAddr = 0;
      int    eFen = 0, eFid = 0, eVld = 0, eRfid = 0, eDet = 0;
      string t = $sformatf("m%0d.c%0d", m, c);
      if (c >= total) begin
         eDone = 1;
      end else begin
         r     = (c - 1) / runLen;
         p     = (c - 1) % runLen;
         eBusy = 1;
         if (r > 0) begin
            eFen = 1;
            eFid = r - 1;
         end
         if (p == 0) begin
            eClr = 1;
         end else if (p == runLen - 1) begin
            if (r > 0) begin
               eVld  = 1;
               eRfid = r - 1;
               eDet  = int'(msk[r-1]);
            end
         end else begin
            eEn    = 1;
            idx    = p - 1;
            dtpLen = (m == 2'b10) ? 0 : 4;
            if (idx < dtpLen) begin
               eAddr = idx;
               eCut  = int'(rom[idx]);
            end else begin
               eCut = rtpSeq[idx - dtpLen];
            end
         end
      end
      checkOutput({t, ".busy"},         32'(busy),        32'(eBusy));
      checkOutput({t, ".done"},         32'(done),        32'(eDone));
      checkOutput({t, ".ora_clr"},      32'(oraClr),      32'(eClr));
      checkOutput({t, ".ora_en"},       32'(oraEn),       32'(eEn));
      checkOutput({t, ".cut_in"},       32'(cutIn),       32'(eCut));
      checkOutput({t, ".dtp_addr"},     32'(dtpAddr),     32'(eAddr));
      checkOutput({t, ".fault_en"},     32'(faultEn),     32'(eFen));
      checkOutput({t, ".fault_id"},     32'(faultId),     32'(eFid));
      checkOutput({t, ".res_vld"},      32'(resVld),      32'(eVld));
      checkOutput({t, ".res_fault_id"}, 32'(resFaultId),  32'(eRfid));
      checkOutput({t, ".res_detected"}, 32'(resDetected), 32'(eDet));
      checkOutput({t, ".det_count"},    32'(detCount),    32'(expectedCount(c, n, msk)));
   endtask

   // Run one sequence from IDLE/DONE: start in cycle 0, then check each cycle.
   // Optionally pulse start, abort, or assert reset at a given cycle.
   task automatic applyStimulus(input logic [1:0] m, input logic [2:0] msk,
                                input int startAt, input int abortAt, input int resetAt);
      int n     = runLength(m);
      int total = 1 + 4 * (n + 2);
      for (int i = 0; i < 4; i++) rom[i] = 4'($urandom);
      detMask = msk;
      @(negedge clk);
      mode  = m;
      start = 1'b1;
      for (int c = 1; c <= total; c++) begin
         @(negedge clk);
         start = (c == startAt);
         abort = 1'b0;
         checkCycle(c, n, m, msk);
         if (c == abortAt) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            checkQuiet("abort", expectedCount(c + 1, n, msk));
            return;
         end
         if (c == resetAt) begin
            #2 rst_n = 1'b0;
            #1 checkQuiet("resetAsync", 0);
            @(negedge clk);
            checkQuiet("resetHeld", 0);
            rst_n = 1'b1;
            return;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      mode    = 2'b00;
      detMask = 3'b000;
      for (int i = 0; i < 4; i++) rom[i] = 4'h0;

      $display("[TB] reset with toggling inputs");
      repeat (4) begin
         @(negedge clk);
         start = 1'($urandom);
         abort = 1'($urandom);
         mode  = 2'($urandom);
         for (int i = 0; i < 4; i++) rom[i] = 4'($urandom);
         checkQuiet("reset", 0);
      end
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checkQuiet("idle", 0);

      $display("[TB] RTP-only sequence");
      applyStimulus(2'b10, 3'b000, 0, 0, 0);

      $display("[TB] DTP+RTP sequence, only fault 1 detectable");
      applyStimulus(2'b00, 3'b010, 0, 0, 0);

      $display("[TB] DTP-only sequence");
      applyStimulus(2'b01, 3'($urandom), 0, 0, 0);

      $display("[TB] randomized sequences");
      repeat (2) applyStimulus(2'($urandom), 3'($urandom), 0, 0, 0);

      $display("[TB] start pulsed while busy");
      applyStimulus(2'b00, 3'($urandom), 9, 0, 0);

      $display("[TB] abort during fault run 2");
      applyStimulus(2'b00, 3'b010, 20, 47, 0);
      @(negedge clk);
      checkQuiet("abortIdle", 1);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      checkQuiet("abortWins", 1);

      $display("[TB] asynchronous reset");
      #2 rst_n = 1'b0;
      #1 checkQuiet("idleReset", 0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(2'b00, 3'($urandom), 0, 0, 20);
      @(negedge clk);
      checkQuiet("postReset", 0);
      applyStimulus(2'($urandom), 3'($urandom), 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
